noc_local_sink: RTL and testbench



---
 rtl/noc_pkg.sv | 48 ++++
 rtl/noc_local_sink.sv | 159 +++++++++++++++
 tb/tb_noc_local_sink.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic-experiment blocks: flit type,
// header field layout, local-sink FSM states and result error bit positions.
package noc_pkg;

    typedef logic [31:0] flit_t;

    // Header flit (F0) field positions
    localparam int SRC_X_HI = 31;
    localparam int SRC_X_LO = 24;
    localparam int SRC_Y_HI = 23;
    localparam int SRC_Y_LO = 16;
    localparam int DST_X_HI = 15;
    localparam int DST_X_LO = 8;
    localparam int DST_Y_HI = 7;
    localparam int DST_Y_LO = 0;

    // Local sink parser states
    typedef enum logic [2:0] {
        HEADER  = 3'd0,
        SIZE    = 3'd1,
        TSTAMP  = 3'd2,
        PKTNUM  = 3'd3,
        PAYLOAD = 3'd4,
        RESULT  = 3'd5
    } sink_state_e;

    // Bit positions inside result_err
    localparam int ERR_DEST    = 0;
    localparam int ERR_SIZE    = 1;
    localparam int ERR_PAYLOAD = 2;

    // First value carried by a payload flit; payload flit p carries p
    localparam flit_t PAYLOAD_FIRST_VALUE = 32'd3;

    // Smallest size that still carries timestamp and packet number
    localparam flit_t MIN_VALID_SIZE = 32'd2;

    // Source coordinates of a header flit as {src_x, src_y}
    function automatic logic [15:0] header_src(input flit_t f);
        return {f[SRC_X_HI:SRC_X_LO], f[SRC_Y_HI:SRC_Y_LO]};
    endfunction

    // Destination coordinates of a header flit as {dst_x, dst_y}
    function automatic logic [15:0] header_dst(input flit_t f);
        return {f[DST_X_HI:DST_X_LO], f[DST_Y_HI:DST_Y_LO]};
    endfunction

endpackage

// File: rtl/noc_local_sink.sv
// Packet receiver for a router Local output port. Consumes flits under the
// credit handshake, parses header/size/timestamp/packet number, checks
// destination and payload, measures latency and hands one result record per
// packet to a statistics collector.
module noc_local_sink #(
    parameter logic [7:0] POS_X      = 8'd0,
    parameter logic [7:0] POS_Y      = 8'd0,
    parameter int         FLIT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_in,
    output logic                  credit_o,
    input  logic [31:0]           cycle_count,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [15:0]           result_src,
    output logic [31:0]           result_size,
    output logic [31:0]           result_pkt_num,
    output logic [31:0]           result_latency,
    output logic [2:0]            result_err,
    output logic [31:0]           pkt_count,
    output logic [31:0]           err_count
);

    import noc_pkg::*;

    sink_state_e state;
    sink_state_e state_next;

    flit_t       flit;
    logic        accept;
    logic        last_flit;
    logic [31:0] remaining;
    logic [31:0] expect_val;
    logic        dest_err;
    logic        size_err;
    logic        payload_err;

    assign flit      = data_in;
    assign credit_o  = !reset && (state != RESULT);
    assign accept    = rx && credit_o;
    // remaining counts flits still owed after the size flit
    assign last_flit = (remaining == 32'd1);

    assign result_valid = (state == RESULT);
    always_comb begin
        result_err              = 3'b000;
        result_err[ERR_DEST]    = dest_err;
        result_err[ERR_SIZE]    = size_err;
        result_err[ERR_PAYLOAD] = payload_err;
    end

    // State register; reset abandons any partial packet
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: advance one field per accepted flit
    always_comb begin
        state_next = state;
        case (state)
            HEADER: begin
                if (accept) state_next = SIZE;
            end
            SIZE: begin
                if (accept) state_next = (flit == 32'd0) ? RESULT : TSTAMP;
            end
            TSTAMP: begin
                if (accept) state_next = last_flit ? RESULT : PKTNUM;
            end
            PKTNUM: begin
                if (accept) state_next = last_flit ? RESULT : PAYLOAD;
            end
            PAYLOAD: begin
                if (accept && last_flit) state_next = RESULT;
            end
            RESULT: begin
                if (result_ready) state_next = HEADER;
            end
            default: state_next = HEADER;
        endcase
    end

    // Field capture, payload checking and completion counters
    always_ff @(posedge clock) begin
        if (reset) begin
            result_src     <= '0;
            result_size    <= '0;
            result_pkt_num <= '0;
            result_latency <= '0;
            dest_err       <= 1'b0;
            size_err       <= 1'b0;
            payload_err    <= 1'b0;
            remaining      <= '0;
            expect_val     <= '0;
            pkt_count      <= '0;
            err_count      <= '0;
        end else begin
            case (state)
                HEADER: begin
                    if (accept) begin
                        // Fields a short packet never reaches read back as zero
                        result_src     <= header_src(flit);
                        dest_err       <= (header_dst(flit) != {POS_X, POS_Y});
                        result_size    <= '0;
                        result_pkt_num <= '0;
                        result_latency <= '0;
                        size_err       <= 1'b0;
                        payload_err    <= 1'b0;
                    end
                end
                SIZE: begin
                    if (accept) begin
                        result_size <= flit;
                        size_err    <= (flit < MIN_VALID_SIZE);
                        remaining   <= flit;
                    end
                end
                TSTAMP: begin
                    if (accept) begin
                        // Modular difference: counter wrap gives the true latency
                        result_latency <= cycle_count - flit;
                        remaining      <= remaining - 32'd1;
                    end
                end
                PKTNUM: begin
                    if (accept) begin
                        result_pkt_num <= flit;
                        remaining      <= remaining - 32'd1;
                        expect_val     <= PAYLOAD_FIRST_VALUE;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (flit != expect_val) payload_err <= 1'b1;
                        expect_val <= expect_val + 32'd1;
                        remaining  <= remaining - 32'd1;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        pkt_count <= pkt_count + 32'd1;
                        if (result_err != 3'b000) err_count <= err_count + 32'd1;
                    end
                end
                default: begin
                    remaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_sink.sv
// Self-checking bench for noc_local_sink: directed table vectors, hand-built
// multi-cycle sequences (ready stall, reset mid-packet) and randomized
// packets checked against a packet-level reference model.
module tb_noc_local_sink;

    localparam logic [7:0] PX = 8'd2;
    localparam logic [7:0] PY = 8'd3;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [31:0] data_in;
    logic        credit_o;
    logic [31:0] cycle_count;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_src;
    logic [31:0] result_size;
    logic [31:0] result_pkt_num;
    logic [31:0] result_latency;
    logic [2:0]  result_err;
    logic [31:0] pkt_count;
    logic [31:0] err_count;

    noc_local_sink #(.POS_X(PX), .POS_Y(PY), .FLIT_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx             (rx),
        .data_in        (data_in),
        .credit_o       (credit_o),
        .cycle_count    (cycle_count),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_src     (result_src),
        .result_size    (result_size),
        .result_pkt_num (result_pkt_num),
        .result_latency (result_latency),
        .result_err     (result_err),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] src;
        logic [31:0] size;
        logic [31:0] pkt;
        logic [31:0] lat;
        logic [2:0]  err;
    } rec_t;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] size;
        logic [31:0] ts;
        logic [31:0] cc;
        logic [31:0] pkt;
        logic [31:0] bad_last;
        int          gap;
        logic [2:0]  exp_err;
        logic [31:0] exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pkt_cnt = 0;
    logic [31:0] exp_err_cnt = 0;

    logic [31:0] pk [0:31];
    int          pk_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled and inputs driven 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
        cycle_count = cycle_count + 32'd1;
    endtask

    // Fill pk[] with a well-formed packet of size s
    task automatic build(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] s,
                         input logic [31:0] ts, input logic [31:0] pkt);
        pk[0] = {src, dst};
        pk[1] = s;
        if (s >= 1) pk[2] = ts;
        if (s >= 2) pk[3] = pkt;
        for (int p = 3; p <= int'(s); p++) pk[p+1] = p;
        pk_len = int'(s) + 2;
    endtask

    // Packet-level reference: the record a correct sink reports for pk[]
    function automatic rec_t model(input logic [31:0] cc_ts);
        rec_t        r;
        logic [31:0] s;
        logic        perr;
        s     = pk[1];
        r.src = pk[0][31:16];
        r.size = s;
        r.lat = (s >= 1) ? (cc_ts - pk[2]) : 32'd0;
        r.pkt = (s >= 2) ? pk[3] : 32'd0;
        perr  = 1'b0;
        for (int p = 3; p <= int'(s); p++) if (pk[p+1] != p) perr = 1'b1;
        r.err = {perr, (s < 2), (pk[0][15:0] != {PX, PY})};
        return r;
    endfunction

    // Drive pk[0..n-1]; gap idle cycles precede every flit after the size flit
    task automatic send_flits(input int n, input logic [31:0] cc_ts, input int gap);
        int w;
        for (int k = 0; k < n; k++) begin
            if (k >= 2 && gap > 0) begin
                rx = 1'b0;
                repeat (gap) step();
            end
            rx = 1'b1;
            data_in = pk[k];
            w = 0;
            while (!credit_o && w < 20) begin
                step();
                w++;
            end
            if (w >= 20) chk("credit_timeout", {31'd0, credit_o}, 32'd1);
            if (k == 2) cycle_count = cc_ts;
            step();
            rx = 1'b0;
        end
    endtask

    // Check the record, optionally stall the collector, then hand it off
    task automatic collect(input rec_t e, input bit chk_pkt, input int ready_delay, input bit hold_rx);
        int w;
        chk("valid_after_last", {31'd0, result_valid}, 32'd1);
        w = 0;
        while (!result_valid && w < 20) begin
            step();
            w++;
        end
        for (int d = 0; d < ready_delay; d++) begin
            if (hold_rx) begin
                rx = 1'b1;
                data_in = 32'h0100_0203;
            end
            result_ready = 1'b0;
            #1;
            chk("credit_in_result", {31'd0, credit_o}, 32'd0);
            chk("valid_hold", {31'd0, result_valid}, 32'd1);
            step();
        end
        rx = 1'b0;
        chk("src", {16'd0, result_src}, {16'd0, e.src});
        chk("size", result_size, e.size);
        chk("latency", result_latency, e.lat);
        chk("err", {29'd0, result_err}, {29'd0, e.err});
        if (chk_pkt) chk("pkt_num", result_pkt_num, e.pkt);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        exp_pkt_cnt = exp_pkt_cnt + 32'd1;
        if (e.err != 3'b000) exp_err_cnt = exp_err_cnt + 32'd1;
        chk("valid_cleared", {31'd0, result_valid}, 32'd0);
        chk("pkt_count", pkt_count, exp_pkt_cnt);
        chk("err_count", err_count, exp_err_cnt);
    endtask

    vec_t tbl [0:5];
    rec_t e;

    initial begin
        rx = 1'b0;
        data_in = '0;
        result_ready = 1'b0;
        cycle_count = '0;
        reset = 1'b1;
        #1;
        step();
        chk("credit_in_reset", {31'd0, credit_o}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        chk("rst_err", {29'd0, result_err}, 32'd0);
        chk("rst_credit", {31'd0, credit_o}, 32'd1);

        //            src       dst       size    ts             cc             pkt    bad_last gap exp_err exp_lat
        tbl[0] = '{16'h0100, 16'h0203, 32'd4, 32'd100,       32'd130,       32'd7, 32'd0, 0, 3'b000, 32'd30};
        tbl[1] = '{16'h0100, 16'h0204, 32'd4, 32'd100,       32'd130,       32'd7, 32'd9, 0, 3'b101, 32'd30};
        tbl[2] = '{16'h0100, 16'h0203, 32'd0, 32'd100,       32'd130,       32'd7, 32'd0, 0, 3'b010, 32'd0};
        tbl[3] = '{16'h0100, 16'h0203, 32'd1, 32'd100,       32'd130,       32'd7, 32'd0, 0, 3'b010, 32'd30};
        tbl[4] = '{16'h0100, 16'h0203, 32'd4, 32'd100,       32'd130,       32'd7, 32'd0, 3, 3'b000, 32'd30};
        tbl[5] = '{16'h0A0B, 16'h0203, 32'd3, 32'hFFFF_FFF0, 32'h0000_0010, 32'd5, 32'd0, 0, 3'b000, 32'h20};

        for (int i = 0; i < 6; i++) begin
            build(tbl[i].src, tbl[i].dst, tbl[i].size, tbl[i].ts, tbl[i].pkt);
            if (tbl[i].bad_last != 0) pk[pk_len-1] = tbl[i].bad_last;
            send_flits(pk_len, tbl[i].cc, tbl[i].gap);
            e.src  = tbl[i].src;
            e.size = tbl[i].size;
            e.pkt  = tbl[i].pkt;
            e.lat  = tbl[i].exp_lat;
            e.err  = tbl[i].exp_err;
            collect(e, tbl[i].size >= 2, 0, 1'b0);
        end

        // Collector stalls 5 cycles with the next header already on rx
        build(16'h0100, 16'h0203, 32'd4, 32'd100, 32'd7);
        send_flits(pk_len, 32'd130, 0);
        e = model(32'd130);
        collect(e, 1'b1, 5, 1'b1);
        build(16'h0100, 16'h0203, 32'd5, 32'd1000, 32'd8);
        send_flits(pk_len, 32'd1234, 0);
        e.src = 16'h0100; e.size = 32'd5; e.pkt = 32'd8; e.lat = 32'd234; e.err = 3'b000;
        collect(e, 1'b1, 0, 1'b0);

        // Randomized packets against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] s;
            logic [31:0] cc;
            s  = $urandom_range(0, 8);
            cc = $urandom;
            build($urandom, ($urandom_range(0, 1) == 1) ? {PX, PY} : 16'($urandom), s, $urandom, $urandom);
            if (s >= 3 && $urandom_range(0, 3) == 0)
                pk[$urandom_range(4, int'(s) + 1)] ^= 32'h0000_0100;
            e = model(cc);
            send_flits(pk_len, cc, $urandom_range(0, 2));
            collect(e, s >= 2, $urandom_range(0, 3), 1'b0);
        end

        // Reset after the timestamp flit discards the partial packet
        build(16'h0100, 16'h0203, 32'd4, 32'd100, 32'd7);
        send_flits(3, 32'd130, 0);
        reset = 1'b1;
        #1;
        chk("credit_mid_reset", {31'd0, credit_o}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        exp_pkt_cnt = 0;
        exp_err_cnt = 0;
        chk("mrst_pkt_count", pkt_count, 32'd0);
        chk("mrst_err_count", err_count, 32'd0);
        chk("mrst_src", {16'd0, result_src}, 32'd0);
        chk("mrst_size", result_size, 32'd0);
        chk("mrst_latency", result_latency, 32'd0);
        chk("mrst_valid", {31'd0, result_valid}, 32'd0);
        build(16'h0302, 16'h0203, 32'd4, 32'd50, 32'd11);
        send_flits(pk_len, 32'd60, 1);
        e.src = 16'h0302; e.size = 32'd4; e.pkt = 32'd11; e.lat = 32'd10; e.err = 3'b000;
        collect(e, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck handshake cannot hang the run
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
